// File: rtl/os_row_sequencer_pkg.sv
// Shared definitions for the output-stationary row sequencer: FSM state
// encodings and the instruction codes driven onto the row's west edge.
package os_row_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FEED  = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] INST_IDLE    = 2'b00;
   localparam logic [1:0] INST_OS_HOLD = 2'b10;
   localparam logic [1:0] INST_OS_EXEC = 2'b11;

endpackage

// File: rtl/os_row_sequencer_serializer.sv
// Captures one OS result per tile and streams them out column by column
// over a valid/ready port.
module os_psum_serializer #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   localparam int IW     = (col > 1) ? $clog2(col) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   capture_en,
   input  logic                   load,
   input  logic [col-1:0]         os_ready,
   input  logic [psum_bw*col-1:0] os_output,
   input  logic                   out_ready,
   output logic                   all_cap,
   output logic                   last_accept,
   output logic [psum_bw-1:0]     out_data,
   output logic [IW-1:0]          out_col,
   output logic                   out_valid
);

   localparam logic [IW-1:0] LAST = IW'(col - 1);

   logic [col-1:0]     cap;
   logic [col-1:0]     hit;
   logic [psum_bw-1:0] data [col];
   logic [IW-1:0]      idx;

   // Only the first ready per column in WAIT lands; later ones are dropped.
   assign hit         = capture_en ? (os_ready & ~cap) : '0;
   assign all_cap     = &(cap | hit);
   assign last_accept = out_valid && out_ready && (idx == LAST);
   assign out_col     = idx;
   // An uncaptured column reads as zero, so the data registers need no clear.
   assign out_data    = (out_valid && cap[idx]) ? data[idx] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (clear) cap <= '0;
         else       cap <= cap | hit;

         if (load) begin
            out_valid <= 1'b1;
            idx       <= '0;
         end else if (out_valid && out_ready) begin
            if (idx == LAST) out_valid <= 1'b0;
            else             idx       <= idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < col; j++) begin
         if (hit[j]) data[j] <= os_output[j*psum_bw +: psum_bw];
      end
   end

endmodule

// File: rtl/os_row_sequencer.sv
// Sequences one output-stationary accumulation pass on a row of tiles:
// issue K executes from L0, wait for skewed tile results, then drain them.
module os_row_sequencer
   import os_row_sequencer_pkg::*;
#(
   parameter int bw       = 4,
   parameter int psum_bw  = 16,
   parameter int col      = 8,
   parameter int WAIT_MAX = 31,
   localparam int CW      = (col > 1) ? $clog2(col) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3:0]             k_len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   l0_rd,
   input  logic                   l0_empty,
   output logic [1:0]             inst_w,
   output logic [3:0]             accum_limit,
   input  logic [col-1:0]         os_ready,
   input  logic [psum_bw*col-1:0] os_output,
   output logic [psum_bw-1:0]     out_data,
   output logic [CW-1:0]          out_col,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int TW = $clog2(WAIT_MAX + 1);

   if (bw < 1 || psum_bw < 1 || col < 2 || WAIT_MAX < 1) begin : g_param_check
      $error("os_row_sequencer: illegal parameter set");
   end

   state_t        state;
   logic [3:0]    issued;
   logic          pending;
   logic [TW-1:0] timer;
   logic [4:0]    sum;
   logic          accept;
   logic          timeout;
   logic          go_drain;
   logic          all_cap;
   logic          last_accept;

   // A read in flight already counts toward k so L0 is never over-read.
   assign sum      = {1'b0, issued} + {4'b0, pending};
   assign l0_rd    = (state == S_FEED) && !l0_empty && (sum < {1'b0, accum_limit});
   assign accept   = (state == S_IDLE) && start && (k_len != 4'd0);
   assign timeout  = (timer == TW'(WAIT_MAX - 1));
   assign go_drain = (state == S_WAIT) && (all_cap || timeout);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         inst_w      <= INST_IDLE;
         accum_limit <= 4'd0;
         issued      <= 4'd0;
         pending     <= 1'b0;
         timer       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state       <= S_FEED;
                  busy        <= 1'b1;
                  err         <= 1'b0;
                  accum_limit <= k_len;
                  inst_w      <= INST_OS_HOLD;
                  issued      <= 4'd0;
                  pending     <= 1'b0;
               end
            end
            S_FEED: begin
               pending <= l0_rd;
               issued  <= issued + {3'b0, pending};
               inst_w  <= l0_rd ? INST_OS_EXEC : INST_OS_HOLD;
               if (pending && (sum == {1'b0, accum_limit})) begin
                  state <= S_WAIT;
                  timer <= '0;
               end
            end
            S_WAIT: begin
               inst_w <= INST_OS_HOLD;
               if (timer != TW'(WAIT_MAX)) timer <= timer + 1'b1;
               if (go_drain) begin
                  state  <= S_DRAIN;
                  inst_w <= INST_IDLE;
                  if (!all_cap) err <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (last_accept) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   os_psum_serializer #(
      .col     (col),
      .psum_bw (psum_bw)
   ) u_ser (
      .clk         (clk),
      .reset       (reset),
      .clear       (accept),
      .capture_en  (state == S_WAIT),
      .load        (go_drain),
      .os_ready    (os_ready),
      .os_output   (os_output),
      .out_ready   (out_ready),
      .all_cap     (all_cap),
      .last_accept (last_accept),
      .out_data    (out_data),
      .out_col     (out_col),
      .out_valid   (out_valid)
   );

endmodule

// File: tb/tb_os_row_sequencer.sv
// Scoreboard bench for os_row_sequencer: directed passes push expected drain
// words; a negedge monitor pops and compares on every accepted word.
module tb_os_row_sequencer;

   localparam int PW   = 16;
   localparam int COL  = 8;
   localparam int WMAX = 31;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [3:0]        k_len = 4'd0;
   logic              busy, done, err, l0_rd;
   logic              l0_empty = 1'b0;
   logic [1:0]        inst_w;
   logic [3:0]        accum_limit;
   logic [COL-1:0]    os_ready = '0;
   logic [PW*COL-1:0] os_output = '0;
   logic [PW-1:0]     out_data;
   logic [2:0]        out_col;
   logic              out_valid;
   logic              out_ready = 1'b1;

   int tests = 0;
   int fails = 0;
   int exec_cnt = 0;
   int rd_cnt = 0;
   int done_cnt = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_w;
   logic        hold_chk = 1'b0;
   logic [PW-1:0] held_data;
   logic [2:0]  held_col;

   os_row_sequencer #(
      .bw(4), .psum_bw(PW), .col(COL), .WAIT_MAX(WMAX)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .busy(busy), .done(done), .err(err), .l0_rd(l0_rd), .l0_empty(l0_empty),
      .inst_w(inst_w), .accum_limit(accum_limit), .os_ready(os_ready),
      .os_output(os_output), .out_data(out_data), .out_col(out_col),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic bound_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   // Monitor: scoreboard pop on handshake, stall stability, event counters.
   always @(negedge clk) begin
      if (reset) begin
         if (hold_chk) begin
            check("stall_data", 32'(out_data), 32'(held_data));
            check("stall_col", 32'(out_col), 32'(held_col));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_word: got col %0d data 0x%0h, expected none", out_col, out_data);
            end else begin
               exp_w = exp_q.pop_front();
               check("drain_word", {16'(out_col), out_data}, exp_w);
            end
         end
         hold_chk  = out_valid && !out_ready;
         held_data = out_data;
         held_col  = out_col;
         if (inst_w == 2'b11) exec_cnt++;
         if (l0_rd) rd_cnt++;
         if (done) done_cnt++;
      end else begin
         hold_chk = 1'b0;
      end
   end

   task automatic recover();
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0; l0_empty = 1'b0; os_ready = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
      check({tag, "_err"}, 32'(err), 32'h0);
      check({tag, "_l0_rd"}, 32'(l0_rd), 32'h0);
      check({tag, "_inst_w"}, 32'(inst_w), 32'h0);
      check({tag, "_accum_limit"}, 32'(accum_limit), 32'h0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_out_data"}, 32'(out_data), 32'h0);
      check({tag, "_out_col"}, 32'(out_col), 32'h0);
   endtask

   // One pass. skip: column whose os_ready never fires (-1 none); rmode 1
   // toggles out_ready 1,0,0,1; abort_col: reset when that column is offered.
   task automatic run_pass(input string tag, input int k, input int empty_at, input int empty_len,
                           input bit junk_feed, input int skip, input int rmode, input int abort_col,
                           input logic [15:0] seed, input bit exp_err, input int exp_bub, input int exp_wait);
      logic [PW*COL-1:0] vals;
      int execs, bub, c, w, i, dcnt, e0, r0, d0;
      bit ok;
      for (int j = 0; j < COL; j++) begin
         vals[j*PW +: PW] = seed + 16'(j) * 16'h0101;
         exp_q.push_back({16'(j), (j == skip) ? 16'h0 : vals[j*PW +: PW]});
      end
      e0 = exec_cnt; r0 = rd_cnt; d0 = done_cnt;

      @(posedge clk); #1;
      start = 1'b1; k_len = 4'(k);
      os_output = junk_feed ? ~vals : vals;
      os_ready  = junk_feed ? '1 : '0;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_feed"}, 32'(busy), 32'h1);
      check({tag, "_err_cleared"}, 32'(err), 32'h0);
      check({tag, "_accum_latched"}, 32'(accum_limit), 32'(k));

      execs = 0; bub = 0; c = 0; ok = 1'b0;
      while (c < 64) begin
         l0_empty = (c >= empty_at) && (c < empty_at + empty_len);
         @(negedge clk);
         if (inst_w == 2'b11) execs++;
         else if (execs > 0) bub++;
         c++;
         @(posedge clk); #1;
         if (execs == k) begin ok = 1'b1; break; end
      end
      l0_empty = 1'b0;
      if (!ok) begin bound_fail({tag, "_feed"}); recover(); return; end
      check({tag, "_bubbles"}, 32'(bub), 32'(exp_bub));

      w = 0; ok = 1'b0;
      while (w < 80) begin
         os_output = vals;
         os_ready  = '0;
         if (w < COL && w != skip) os_ready[w] = 1'b1;
         if (w == 9) begin
            os_ready = '1;
            if (skip >= 0) os_ready[skip] = 1'b0;
            os_output = ~vals;
         end
         if (w == 2) begin start = 1'b1; k_len = 4'd9; end
         else start = 1'b0;
         @(posedge clk); #1;
         w++;
         if (out_valid) begin ok = 1'b1; break; end
      end
      os_ready = '0; start = 1'b0; os_output = vals;
      if (!ok) begin bound_fail({tag, "_wait"}); recover(); return; end
      check({tag, "_wait_cycles"}, 32'(w), 32'(exp_wait));
      check({tag, "_err_drain"}, 32'(err), 32'(exp_err));

      i = 0; dcnt = 0; ok = 1'b0;
      while (i < 80) begin
         out_ready = (rmode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
         if (out_valid) dcnt++;
         if (abort_col >= 0 && out_valid && out_col == 3'(abort_col)) begin
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            check_reset_outputs({tag, "_abort"});
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            exp_q.delete();
            out_ready = 1'b1;
            check({tag, "_abort_no_done"}, 32'(done_cnt - d0), 32'h0);
            return;
         end
         @(posedge clk); #1;
         i++;
      end
      out_ready = 1'b1;
      if (!ok) begin bound_fail({tag, "_drain"}); recover(); return; end
      check({tag, "_err_done"}, 32'(err), 32'(exp_err));
      check({tag, "_busy_done"}, 32'(busy), 32'h1);
      check({tag, "_accum_hold"}, 32'(accum_limit), 32'(k));
      @(posedge clk); #1;
      check({tag, "_busy_idle"}, 32'(busy), 32'h0);
      check({tag, "_done_pulse"}, 32'(done), 32'h0);
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
      check({tag, "_exec_count"}, 32'(exec_cnt - e0), 32'(k));
      check({tag, "_rd_count"}, 32'(rd_cnt - r0), 32'(k));
      check({tag, "_words_left"}, 32'(exp_q.size()), 32'h0);
      if (rmode == 0) check({tag, "_drain_cycles"}, 32'(dcnt), 32'(COL));
   endtask

   task automatic idle_ignore(input logic [3:0] prev_limit);
      int r0, d0;
      r0 = rd_cnt; d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; k_len = 4'd0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("k0_busy", 32'(busy), 32'h0);
         check("k0_inst_w", 32'(inst_w), 32'h0);
      end
      @(posedge clk); #1;
      check("k0_rd_count", 32'(rd_cnt - r0), 32'h0);
      check("k0_done_count", 32'(done_cnt - d0), 32'h0);
      check("k0_accum_limit", 32'(accum_limit), 32'(prev_limit));
   endtask

   initial begin
      #2;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b1;
      @(posedge clk); #1;

      run_pass("t1_basic",   4, 0, 0, 1'b0, -1, 0, -1, 16'h1000, 1'b0, 0, 8);
      run_pass("t2_l0stall", 3, 2, 2, 1'b1, -1, 0, -1, 16'h2345, 1'b0, 2, 8);
      run_pass("t4_timeout", 5, 0, 0, 1'b0,  5, 0, -1, 16'h4000, 1'b1, 0, WMAX);
      run_pass("t3_backpr",  2, 0, 0, 1'b0, -1, 1, -1, 16'h8001, 1'b0, 0, 8);
      idle_ignore(4'd2);
      run_pass("t5_abort",   6, 0, 0, 1'b0, -1, 0,  3, 16'h5A00, 1'b0, 0, 8);
      run_pass("t5_clean",   1, 0, 0, 1'b0, -1, 0, -1, 16'hC0DE, 1'b0, 0, 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule
